// File: rtl/button_gesture_if.sv
// Button gesture interface: debounced level in, registered held level and event pulses out.
interface button_gesture_if;
  logic clean_in;
  logic held_out;
  logic press_out;
  logic release_out;
  logic click_out;
  logic double_click_out;
  logic long_press_out;

  // Driver side: supplies the debounced level and consumes the events.
  modport master (
    output clean_in,
    input  held_out, press_out, release_out, click_out, double_click_out, long_press_out
  );

  // Gesture block side.
  modport slave (
    input  clean_in,
    output held_out, press_out, release_out, click_out, double_click_out, long_press_out
  );
endinterface

// File: rtl/button_gesture.sv
// Turns one debounced button level into press/release/click/double-click/long-press pulses
// plus a registered held level. All outputs are registered.
module button_gesture #(
  parameter int unsigned CLK_PERIOD_NS = 13,
  parameter int unsigned LONG_PRESS_MS = 500,
  parameter int unsigned DOUBLE_GAP_MS = 250,
  parameter bit          PRESSED_LEVEL = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  button_gesture_if.slave   btn
);

  // ms-to-cycle conversion, rounded up, done in 64 bits to avoid overflow.
  localparam longint unsigned LONG_CYCLES_L =
    (64'(LONG_PRESS_MS) * 64'd1000000 + 64'(CLK_PERIOD_NS) - 64'd1) / 64'(CLK_PERIOD_NS);
  localparam longint unsigned GAP_CYCLES_L =
    (64'(DOUBLE_GAP_MS) * 64'd1000000 + 64'(CLK_PERIOD_NS) - 64'd1) / 64'(CLK_PERIOD_NS);
  localparam int unsigned LONG_CYCLES = 32'(LONG_CYCLES_L);
  localparam int unsigned GAP_CYCLES  = 32'(GAP_CYCLES_L);
  localparam int unsigned MAX_CYCLES  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W       = 32'($clog2(MAX_CYCLES + 1));

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             prev_q, prev_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             double_q, double_d;
  logic             long_q, long_d;

  logic             p_c;
  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] counter_inc_c;

  assign p_c           = (btn.clean_in == PRESSED_LEVEL);
  assign rise_c        = p_c & ~prev_q;
  assign fall_c        = ~p_c & prev_q;
  assign counter_inc_c = (counter_q == CNT_MAX) ? counter_q : counter_q + CNT_W'(1);

  // Gesture FSM next-state and pulse generation; release beats long press, rise beats click.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    prev_d    = p_c;
    held_d    = p_c;
    press_d   = rise_c;
    release_d = fall_c;
    click_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d   = PRESS1;
          counter_d = '0;
        end
      end
      PRESS1: begin
        if (fall_c) begin
          state_d   = GAP;
          counter_d = '0;
        end else if (counter_q == LONG_LAST) begin
          long_d    = 1'b1;
          state_d   = LONG;
          counter_d = '0;
        end else begin
          counter_d = counter_inc_c;
        end
      end
      LONG: begin
        if (fall_c) begin
          state_d   = IDLE;
          counter_d = '0;
        end
      end
      GAP: begin
        if (rise_c) begin
          state_d   = PRESS2;
          counter_d = '0;
        end else if (counter_q == GAP_LAST) begin
          click_d   = 1'b1;
          state_d   = IDLE;
          counter_d = '0;
        end else begin
          counter_d = counter_inc_c;
        end
      end
      PRESS2: begin
        if (fall_c) begin
          double_d  = 1'b1;
          state_d   = IDLE;
          counter_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
  end

  // Reset still tracks the level so a button held through reset yields no press.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      counter_q <= '0;
      prev_q    <= p_c;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      prev_q    <= prev_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  assign btn.held_out         = held_q;
  assign btn.press_out        = press_q;
  assign btn.release_out      = release_q;
  assign btn.click_out        = click_q;
  assign btn.double_click_out = double_q;
  assign btn.long_press_out   = long_q;

endmodule
